mem_wb_pipe: RTL and testbench

Pipeline register and control block between the Memory stage and the Write-Back stage. It captures the data-cache result or the ALU result each time the Memory stage completes. It inserts write-back bubbles while the data cache stalls, sequences the halt, and holds a sticky error flag. It also keeps an optional saturating count of data-cache stall cycles.

---
 rtl/mem_wb_pipe.sv | 174 +++++++++++++++++
 tb/tb_mem_wb_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// -----------------------------------------------------------------------------
// mem_wb_pipe
//
// Purpose:
//   Pipeline register and control block between the Memory stage and the
//   Write-Back stage. Each time the Memory stage completes an instruction
//   (DC_Stall low), it captures either the data-cache read data or the ALU
//   result. While the data cache stalls, it issues write-back bubbles. It also
//   sequences the processor halt, keeps a sticky error flag and optionally
//   keeps a saturating count of data-cache stall cycles.
//
// Configuration macro:
//   MEM_WB_PERF_EN - when defined, builds the 16-bit saturating stall-cycle
//                    counter. When undefined, StallCnt is tied to 16'h0000
//                    and no counter register exists.
//
// Ports:
//   clk          in   1   system clock, rising-edge active
//   rst          in   1   synchronous active-high master reset
//   DC_Stall     in   1   Memory-stage instruction not yet complete
//   MemOut       in  16   data-cache read data
//   XOut         in  16   ALU result / effective address
//   RegWrite     in   1   instruction writes the register file
//   MemToReg     in   1   1: write back MemOut, 0: write back XOut
//   WriteReg     in   3   destination register number
//   Halt         in   1   Memory-stage instruction is HALT
//   err_in       in   1   error reported by the Memory stage
//   WB_Data      out 16   registered write-back data
//   WB_Reg       out  3   registered destination register
//   WB_RegWrite  out  1   register-file write enable for Write-Back
//   WB_Halt      out  1   processor halted, sticky until reset
//   err          out  1   sticky error flag
//   StallCnt     out 16   saturating data-cache stall-cycle count
// -----------------------------------------------------------------------------
module mem_wb_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        DC_Stall,
    input  logic [15:0] MemOut,
    input  logic [15:0] XOut,
    input  logic        RegWrite,
    input  logic        MemToReg,
    input  logic [2:0]  WriteReg,
    input  logic        Halt,
    input  logic        err_in,
    output logic [15:0] WB_Data,
    output logic [2:0]  WB_Reg,
    output logic        WB_RegWrite,
    output logic        WB_Halt,
    output logic        err,
    output logic [15:0] StallCnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_STALL  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    state_t      state_q,       state_d;
    logic [15:0] wb_data_q,     wb_data_d;
    logic [2:0]  wb_reg_q,      wb_reg_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic        wb_halt_q,     wb_halt_d;
    logic        err_q,         err_d;

    // Next-state and next-output logic for the write-back control FSM.
    always_comb begin
        state_d       = state_q;
        wb_data_d     = wb_data_q;
        wb_reg_d      = wb_reg_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_halt_d     = wb_halt_q;
        err_d         = err_q;

        case (state_q)
            // RUN and STALL react identically to the inputs. The state only
            // records whether the previous edge was a bubble.
            ST_RUN, ST_STALL: begin
                if (err_in) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end

                if (DC_Stall) begin
                    // Stall wins over Halt: the bubble holds data and register.
                    state_d       = ST_STALL;
                    wb_regwrite_d = 1'b0;
                end else begin
                    if (MemToReg) begin
                        wb_data_d = MemOut;
                    end else begin
                        wb_data_d = XOut;
                    end
                    wb_reg_d      = WriteReg;
                    wb_regwrite_d = RegWrite;
                    if (Halt) begin
                        state_d   = ST_HALTED;
                        wb_halt_d = 1'b1;
                    end else begin
                        state_d   = ST_RUN;
                    end
                end
            end

            // Terminal state: only rst leaves it. Data and register hold.
            ST_HALTED: begin
                state_d       = ST_HALTED;
                wb_regwrite_d = 1'b0;
                wb_halt_d     = 1'b1;
            end

            // An unreachable encoding recovers to RUN without writing back.
            default: begin
                state_d       = ST_RUN;
                wb_regwrite_d = 1'b0;
            end
        endcase
    end

    // State and output registers, with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wb_data_q     <= 16'h0000;
            wb_reg_q      <= 3'b000;
            wb_regwrite_q <= 1'b0;
            wb_halt_q     <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wb_data_q     <= wb_data_d;
            wb_reg_q      <= wb_reg_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_halt_q     <= wb_halt_d;
            err_q         <= err_d;
        end
    end

`ifdef MEM_WB_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating stall-cycle counter. Frozen once halted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (DC_Stall && (state_q != ST_HALTED) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'h0001;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
`else
    assign StallCnt = 16'h0000;
`endif

    assign WB_Data     = wb_data_q;
    assign WB_Reg      = wb_reg_q;
    assign WB_RegWrite = wb_regwrite_q;
    assign WB_Halt     = wb_halt_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_pipe
//
// Self-checking bench for mem_wb_pipe. A behavioural model tracks what each
// output must hold after every rising edge. One compare process checks all
// outputs on every falling edge. Directed scenarios add literal checks that
// pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_mem_wb_pipe;

`ifdef MEM_WB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        DC_Stall;
    logic [15:0] MemOut;
    logic [15:0] XOut;
    logic        RegWrite;
    logic        MemToReg;
    logic [2:0]  WriteReg;
    logic        Halt;
    logic        err_in;
    logic [15:0] WB_Data;
    logic [2:0]  WB_Reg;
    logic        WB_RegWrite;
    logic        WB_Halt;
    logic        err;
    logic [15:0] StallCnt;

    mem_wb_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .DC_Stall    (DC_Stall),
        .MemOut      (MemOut),
        .XOut        (XOut),
        .RegWrite    (RegWrite),
        .MemToReg    (MemToReg),
        .WriteReg    (WriteReg),
        .Halt        (Halt),
        .err_in      (err_in),
        .WB_Data     (WB_Data),
        .WB_Reg      (WB_Reg),
        .WB_RegWrite (WB_RegWrite),
        .WB_Halt     (WB_Halt),
        .err         (err),
        .StallCnt    (StallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Behavioural model of the visible write-back state.
    logic [15:0] m_data;
    logic [2:0]  m_reg;
    logic        m_we;
    logic        m_halt;
    logic        m_err;
    int          m_cnt;
    bit          m_halted;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model update on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_data = 16'h0000; m_reg = 3'd0; m_we = 1'b0; m_halt = 1'b0;
            m_err = 1'b0; m_cnt = 0; m_halted = 1'b0;
        end else if (m_halted) begin
            m_we = 1'b0;
        end else begin
            if (err_in) m_err = 1'b1;
            if (DC_Stall) begin
                m_we = 1'b0;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end else begin
                m_data = MemToReg ? MemOut : XOut;
                m_reg  = WriteReg;
                m_we   = RegWrite;
                if (Halt) begin
                    m_halted = 1'b1;
                    m_halt   = 1'b1;
                end
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("WB_Data",     WB_Data,            m_data);
            chk("WB_Reg",      {13'd0, WB_Reg},    {13'd0, m_reg});
            chk("WB_RegWrite", {15'd0, WB_RegWrite}, {15'd0, m_we});
            chk("WB_Halt",     {15'd0, WB_Halt},   {15'd0, m_halt});
            chk("err",         {15'd0, err},       {15'd0, m_err});
            chk("StallCnt",    StallCnt,           PERF ? 16'(m_cnt) : 16'h0000);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_in(input logic st, input logic [15:0] mo, input logic [15:0] xo,
                          input logic rw, input logic m2r, input logic [2:0] wr,
                          input logic h, input logic e);
        DC_Stall = st; MemOut = mo; XOut = xo; RegWrite = rw;
        MemToReg = m2r; WriteReg = wr; Halt = h; err_in = e;
    endtask

    task automatic idle();
        set_in(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) step();
        rst = 1'b0;
    endtask

    logic [15:0] traffic [10];

    initial begin
        traffic = '{16'h0001, 16'h8000, 16'hFFFF, 16'h5A5A, 16'hA5A5,
                    16'h0F0F, 16'hF0F0, 16'h1357, 16'h2468, 16'h7FFF};
        rst = 1'b1;
        set_in(1'b1, 16'hDEAD, 16'hCAFE, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1);
        step();
        chk_en = 1'b1;
        // Reset with arbitrary, hostile inputs.
        do_reset(2);
        chk("rst WB_Data", WB_Data, 16'h0000);
        chk("rst StallCnt", StallCnt, 16'h0000);
        chk("rst flags", {12'd0, WB_RegWrite, WB_Halt, err, 1'b0}, 16'h0000);

        // ALU write-back.
        set_in(1'b0, 16'h9999, 16'h1234, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0);
        step();
        chk("alu WB_Data", WB_Data, 16'h1234);
        chk("alu WB_Reg", {13'd0, WB_Reg}, 16'd5);
        chk("alu WB_RegWrite", {15'd0, WB_RegWrite}, 16'd1);

        // Load under a three-cycle stall.
        set_in(1'b1, 16'h0000, 16'h0040, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall bubble", {15'd0, WB_RegWrite}, 16'd0);
            chk("stall hold data", WB_Data, 16'h1234);
        end
        set_in(1'b0, 16'hBEEF, 16'h0040, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
        step();
        chk("load WB_Data", WB_Data, 16'hBEEF);
        chk("load WB_RegWrite", {15'd0, WB_RegWrite}, 16'd1);
        chk("load StallCnt", StallCnt, PERF ? 16'd3 : 16'd0);
        idle();
        step();
        chk("load once", {15'd0, WB_RegWrite}, 16'd0);

        // Error pulse, then ten cycles of normal traffic.
        set_in(1'b0, 16'h0000, 16'h0011, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 10; i++) begin
            set_in(i[0], traffic[i], ~traffic[i], 1'b1, i[1], i[2:0], 1'b0, 1'b0);
            step();
            chk("err sticky", {15'd0, err}, 16'd1);
        end
        do_reset(1);
        chk("err cleared", {15'd0, err}, 16'd0);

        // Reset in the middle of a stall.
        set_in(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0);
        step(); step();
        do_reset(1);
        chk("mid-stall rst", StallCnt, 16'h0000);

        // Halt held back by a stall, then completed with err_in.
        set_in(1'b1, 16'h0000, 16'hAAAA, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("halt waits", {15'd0, WB_Halt}, 16'd0);
        end
        set_in(1'b0, 16'h0000, 16'hAAAA, 1'b1, 1'b0, 3'd6, 1'b1, 1'b1);
        step();
        chk("halt WB_Halt", {15'd0, WB_Halt}, 16'd1);
        chk("halt err", {15'd0, err}, 16'd1);
        chk("halt WB_Data", WB_Data, 16'hAAAA);
        chk("halt last write", {15'd0, WB_RegWrite}, 16'd1);
        for (int i = 0; i < 5; i++) begin
            set_in(i[0], 16'h5555, 16'h3333, 1'b1, i[1], 3'd1, 1'b0, 1'b1);
            step();
            chk("halted no write", {15'd0, WB_RegWrite}, 16'd0);
            chk("halted hold", WB_Data, 16'hAAAA);
            chk("halted cnt", StallCnt, PERF ? 16'd2 : 16'd0);
        end
        do_reset(1);
        chk("halt cleared", {15'd0, WB_Halt}, 16'd0);

        // Err_in ignored while halted.
        set_in(1'b0, 16'h0000, 16'h0077, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        step();
        set_in(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        step(); step();
        chk("halted err ignored", {15'd0, err}, 16'd0);
        do_reset(1);

        // Stall counter saturation (or stays zero when not built).
        set_in(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        if (PERF) begin
            for (int i = 0; i < 65534; i++) step();
            chk("cnt FFFE", StallCnt, 16'hFFFE);
            for (int i = 0; i < 3; i++) step();
            chk("cnt sat", StallCnt, 16'hFFFF);
        end else begin
            for (int i = 0; i < 20; i++) step();
            chk("cnt absent", StallCnt, 16'h0000);
        end
        idle();
        step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
